// File: rtl/display_arbiter_pkg.sv
// Shared types and constants for the display arbiter and its serial BCD converter.
package display_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam int DIGITS      = 4;
    localparam int BCD_W       = 4;
    localparam int BCD_BITS    = DIGITS * BCD_W;
    localparam int MAX_DISPLAY = 9999;

    // Double-dabble correction: any nibble >= 5 gets +3 before the shift.
    function automatic logic [BCD_BITS-1:0] dabble_adjust(input logic [BCD_BITS-1:0] bcd);
        logic [BCD_BITS-1:0] r;
        for (int i = 0; i < DIGITS; i++) begin
            r[i*BCD_W +: BCD_W] = (bcd[i*BCD_W +: BCD_W] >= 4'd5) ?
                                  bcd[i*BCD_W +: BCD_W] + 4'd3 : bcd[i*BCD_W +: BCD_W];
        end
        return r;
    endfunction

endpackage

// File: rtl/display_arbiter_bin2bcd_serial.sv
// Serial binary-to-BCD converter: one double-dabble step per clock, BIN_W steps.
// done is high for the single cycle after the last shift, while bcd holds the result.
module bin2bcd_serial
    import display_pkg::*;
#(
    parameter int BIN_W = 14
) (
    input  logic                clk,
    input  logic                RESET_N,
    input  logic                start,
    input  logic [BIN_W-1:0]    bin,
    output logic                done,
    output logic [BCD_BITS-1:0] bcd
);

    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W);

    logic [BIN_W-1:0]    r_bin;
    logic [BCD_BITS-1:0] r_bcd;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_active;
    logic [BCD_BITS-1:0] w_adj;

    assign w_adj = dabble_adjust(r_bcd);

    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            r_bin    <= '0;
            r_bcd    <= '0;
            r_cnt    <= '0;
            r_active <= 1'b0;
        end else if (start) begin
            r_bin    <= bin;
            r_bcd    <= '0;
            r_cnt    <= '0;
            r_active <= 1'b1;
        end else if (r_active) begin
            if (r_cnt == CNT_LAST) begin
                r_active <= 1'b0;
            end else begin
                {r_bcd, r_bin} <= {w_adj[BCD_BITS-2:0], r_bin, 1'b0};
                r_cnt          <= r_cnt + 1'b1;
            end
        end
    end

    assign done = r_active && (r_cnt == CNT_LAST);
    assign bcd  = r_bcd;

endmodule

// File: rtl/display_arbiter.sv
// Arbitrates the 4-digit BCD display between a live binary count and a held alert message.
// Optional build macro OVERFLOW_FLAG_EN adds the ovf output (live value was saturated).
module display_arbiter
    import display_pkg::*;
#(
    parameter int BIN_W       = 14,
    parameter int HOLD_CYCLES = 200_000_000
) (
    input  logic                clk,
    input  logic                RESET_N,
    input  logic                live_valid,
    input  logic [BIN_W-1:0]    live_bin,
    output logic                live_done,
    input  logic                alert_req,
    input  logic [BCD_BITS-1:0] alert_bcd,
    output logic                alert_ack,
    output logic                busy,
    output logic [BCD_W-1:0]    ones,
    output logic [BCD_W-1:0]    tens,
    output logic [BCD_W-1:0]    hundreds,
    output logic [BCD_W-1:0]    thousands
`ifdef OVERFLOW_FLAG_EN
    ,
    output logic                ovf
`endif
);

    localparam int TMR_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(HOLD_CYCLES - 1);

    state_t              r_state;
    logic [TMR_W-1:0]    r_tmr;
    logic                r_done;
    logic                r_ack;
    logic [BCD_W-1:0]    r_ones, r_tens, r_hundreds, r_thousands;
`ifdef OVERFLOW_FLAG_EN
    logic                r_sat;
    logic                r_ovf;
`endif

    logic                w_sat;
    logic [BIN_W-1:0]    w_bin_sat;
    logic                w_start;
    logic                w_conv_done;
    logic [BCD_BITS-1:0] w_bcd;

    assign w_sat     = 32'(live_bin) > MAX_DISPLAY;
    assign w_bin_sat = w_sat ? BIN_W'(MAX_DISPLAY) : live_bin;
    assign w_start   = (r_state == IDLE) && !alert_req && live_valid;

    bin2bcd_serial #(.BIN_W(BIN_W)) u_bin2bcd (
        .clk     (clk),
        .RESET_N (RESET_N),
        .start   (w_start),
        .bin     (w_bin_sat),
        .done    (w_conv_done),
        .bcd     (w_bcd)
    );

    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state     <= IDLE;
            r_tmr       <= '0;
            r_done      <= 1'b0;
            r_ack       <= 1'b0;
            r_ones      <= '0;
            r_tens      <= '0;
            r_hundreds  <= '0;
            r_thousands <= '0;
`ifdef OVERFLOW_FLAG_EN
            r_sat       <= 1'b0;
            r_ovf       <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            r_ack  <= 1'b0;
            case (r_state)
                IDLE: begin
                    // Alert wins over a simultaneous live request.
                    if (alert_req) begin
                        {r_thousands, r_hundreds, r_tens, r_ones} <= alert_bcd;
                        r_ack   <= 1'b1;
                        r_tmr   <= '0;
                        r_state <= HOLD;
`ifdef OVERFLOW_FLAG_EN
                        r_ovf   <= 1'b0;
`endif
                    end else if (live_valid) begin
                        r_state <= CONV;
`ifdef OVERFLOW_FLAG_EN
                        r_sat   <= w_sat;
`endif
                    end
                end
                CONV: begin
                    if (w_conv_done) begin
                        {r_thousands, r_hundreds, r_tens, r_ones} <= w_bcd;
                        r_done  <= 1'b1;
                        r_state <= IDLE;
`ifdef OVERFLOW_FLAG_EN
                        r_ovf   <= r_sat;
`endif
                    end
                end
                HOLD: begin
                    if (r_tmr == TMR_LAST) begin
                        r_state <= IDLE;
                    end else begin
                        r_tmr <= r_tmr + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy      = (r_state != IDLE);
    assign live_done = r_done;
    assign alert_ack = r_ack;
    assign ones      = r_ones;
    assign tens      = r_tens;
    assign hundreds  = r_hundreds;
    assign thousands = r_thousands;
`ifdef OVERFLOW_FLAG_EN
    assign ovf       = r_ovf;
`endif

endmodule

// File: tb/tb_display_arbiter.sv
// Self-checking bench for display_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level model of the display.
`timescale 1ns/1ps
module tb_display_arbiter;

    localparam int BIN_W = 14;
    localparam int HOLD  = 8;

    logic             clk        = 1'b0;
    logic             RESET_N    = 1'b1;
    logic             live_valid = 1'b0;
    logic [BIN_W-1:0] live_bin   = '0;
    logic             alert_req  = 1'b0;
    logic [15:0]      alert_bcd  = '0;
    logic             live_done, alert_ack, busy;
    logic [3:0]       ones, tens, hundreds, thousands;
`ifdef OVERFLOW_FLAG_EN
    logic             ovf;
`endif

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 0;

    always #5 clk = ~clk;

    display_arbiter #(.BIN_W(BIN_W), .HOLD_CYCLES(HOLD)) dut (
        .clk        (clk),
        .RESET_N    (RESET_N),
        .live_valid (live_valid),
        .live_bin   (live_bin),
        .live_done  (live_done),
        .alert_req  (alert_req),
        .alert_bcd  (alert_bcd),
        .alert_ack  (alert_ack),
        .busy       (busy),
        .ones       (ones),
        .tens       (tens),
        .hundreds   (hundreds),
        .thousands  (thousands)
`ifdef OVERFLOW_FLAG_EN
        ,
        .ovf        (ovf)
`endif
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the display is "occupied" for a number of cycles after each accepted request;
    // a live value appears on the digits (as its decimal digits) when its occupancy ends.
    int m_left = 0;
    int m_pend = -1;
    int m_dig[4] = '{0, 0, 0, 0};
    bit m_done = 0, m_ack = 0, m_sat = 0, m_ovf = 0;

    always @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            m_left = 0; m_pend = -1; m_dig = '{0, 0, 0, 0};
            m_done = 0; m_ack = 0; m_sat = 0; m_ovf = 0;
        end else begin
            m_done = 0;
            m_ack  = 0;
            if (m_left == 0) begin
                if (alert_req) begin
                    for (int i = 0; i < 4; i++) m_dig[i] = (int'(alert_bcd) >> (4 * i)) & 15;
                    m_ack  = 1;
                    m_left = HOLD;
                    m_ovf  = 0;
                end else if (live_valid) begin
                    m_sat  = int'(live_bin) > 9999;
                    m_pend = m_sat ? 9999 : int'(live_bin);
                    m_left = BIN_W + 1;
                end
            end else begin
                m_left--;
                if (m_left == 0 && m_pend >= 0) begin
                    m_dig[0] = m_pend % 10;
                    m_dig[1] = (m_pend / 10) % 10;
                    m_dig[2] = (m_pend / 100) % 10;
                    m_dig[3] = (m_pend / 1000) % 10;
                    m_done = 1;
                    m_ovf  = m_sat;
                    m_pend = -1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("ones", ones, m_dig[0]);
            chk("tens", tens, m_dig[1]);
            chk("hundreds", hundreds, m_dig[2]);
            chk("thousands", thousands, m_dig[3]);
            chk("busy", busy, int'(m_left != 0));
            chk("live_done", live_done, m_done);
            chk("alert_ack", alert_ack, m_ack);
`ifdef OVERFLOW_FLAG_EN
            chk("ovf", ovf, m_ovf);
`endif
        end
    end

    // Advance one clock; the alert requester drops its request as soon as it sees the ack.
    task automatic step();
        @(posedge clk);
        #1;
        if (alert_ack) alert_req = 1'b0;
        #1;
    endtask

    task automatic chk_digits(input string tag, input int th, input int hu, input int te, input int on);
        chk({tag, "_th"}, thousands, th);
        chk({tag, "_hu"}, hundreds, hu);
        chk({tag, "_te"}, tens, te);
        chk({tag, "_on"}, ones, on);
    endtask

    task automatic wait_done(input string tag, output int k);
        bit seen;
        seen = 0;
        k = 0;
        while (!seen && k < 40) begin
            @(negedge clk);
            k++;
            if (live_done) seen = 1;
        end
        chk({tag, "_done_seen"}, int'(seen), 1);
    endtask

    task automatic live_conv(input string tag, input int v, input int th, input int hu,
                             input int te, input int on);
        int k, nb;
        live_bin   = BIN_W'(v);
        live_valid = 1'b1;
        step();
        live_valid = 1'b0;
        k  = 0;
        nb = 0;
        repeat (40) begin
            @(negedge clk);
            k++;
            if (live_done) break;
            if (busy) nb++;
        end
        chk({tag, "_latency"}, k, 16);
        chk({tag, "_busy_cycles"}, nb, 15);
        chk_digits(tag, th, hu, te, on);
    endtask

    initial begin
        int k, nd, nb;

        #1 RESET_N = 1'b0;
        #1 chk_en = 1;
        repeat (3) step();
        RESET_N = 1'b1;
        #1;
        chk_digits("reset", 0, 0, 0, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", live_done, 0);
        chk("reset_ack", alert_ack, 0);

        live_conv("conv1234", 1234, 1, 2, 3, 4);
        live_conv("sat", 12000, 9, 9, 9, 9);
`ifdef OVERFLOW_FLAG_EN
        chk("sat_ovf", ovf, 1);
`endif
        live_conv("conv42", 42, 0, 0, 4, 2);
`ifdef OVERFLOW_FLAG_EN
        chk("conv42_ovf", ovf, 0);
`endif

        // Alert and live requested together; live pulses during the hold are ignored.
        alert_bcd  = 16'h0420;
        alert_req  = 1'b1;
        live_bin   = BIN_W'(555);
        live_valid = 1'b1;
        step();
        chk("prio_ack", alert_ack, 1);
        live_valid = 1'b0;
        for (int h = 1; h <= HOLD; h++) begin
            @(negedge clk);
            chk("hold_busy", busy, 1);
            chk_digits("hold", 0, 4, 2, 0);
            step();
            live_valid = (h == 2 || h == 4 || h == 7 || h == 8);
        end
        @(negedge clk);
        chk("hold_end_busy", busy, 0);
        chk_digits("hold_end", 0, 4, 2, 0);
        step();
        live_valid = 1'b0;
        wait_done("after_hold", k);
        chk("after_hold_latency", k, 16);
        chk_digits("after_hold", 0, 5, 5, 5);

        // Alert raised mid-conversion waits for the live value to land first.
        live_bin   = BIN_W'(77);
        live_valid = 1'b1;
        step();
        live_valid = 1'b0;
        repeat (4) step();
        alert_bcd = 16'h9A3F;
        alert_req = 1'b1;
        wait_done("nopreempt", k);
        chk("nopreempt_latency", k, 12);
        chk_digits("nopreempt", 0, 0, 7, 7);
        chk("nopreempt_no_ack_yet", alert_ack, 0);
        @(negedge clk);
        chk("nopreempt_ack", alert_ack, 1);
        chk_digits("passthru", 9, 10, 3, 15);
        alert_req = 1'b0;
        repeat (HOLD + 2) step();

        // Reset in the middle of a conversion discards it.
        live_bin   = BIN_W'(5000);
        live_valid = 1'b1;
        step();
        live_valid = 1'b0;
        repeat (5) step();
        RESET_N = 1'b0;
        #1;
        chk_digits("rst_conv", 0, 0, 0, 0);
        chk("rst_conv_busy", busy, 0);
        repeat (2) step();
        RESET_N = 1'b1;
        nd = 0;
        nb = 0;
        repeat (20) begin
            @(negedge clk);
            if (live_done) nd++;
            if (busy) nb++;
        end
        chk("rst_conv_no_done", nd, 0);
        chk("rst_conv_idle", nb, 0);

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            step();
            live_valid = ($urandom_range(0, 9) < 3);
            live_bin   = ($urandom_range(0, 3) == 0) ? BIN_W'($urandom_range(9990, 16383))
                                                     : BIN_W'($urandom_range(0, 9999));
            if (!alert_req && $urandom_range(0, 29) == 0) begin
                alert_req = 1'b1;
                alert_bcd = 16'($urandom);
            end
            RESET_N = ($urandom_range(0, 999) != 0);
        end
        RESET_N = 1'b1;
        repeat (30) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
